fifo_ctrl_16x8: RTL and testbench

Synchronous FIFO controller that acts as the initiator for the team's 16x8 dual-port synchronous RAM. It turns producer push and consumer pop requests into RAM write and read strobes and addresses, and tracks occupancy. It reports full/empty/count, sticky overflow/underflow errors, and a read-valid strobe aligned with the RAM's registered read data. Data never passes through this block: producer data goes straight to the RAM data input, and the consumer takes read data from the RAM data output.

---
 rtl/fifo_ctrl_16x8_pkg.sv | 25 ++
 rtl/fifo_ctrl_16x8.sv | 80 ++++++++
 tb/tb_fifo_ctrl_16x8.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_16x8_pkg.sv
// Shared constants and error-flag helpers for the 16x8 FIFO controller.
// The sticky-flag update rule lives here so every user applies the same priority.
package fifo_ctrl_16x8_pkg;

    localparam int unsigned FifoAwDefault = 4;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // A new error in the same cycle as clr_err wins over the clear.
    function automatic fifo_err_t fifo_err_next(
        input fifo_err_t cur,
        input logic      ovf_evt,
        input logic      udf_evt,
        input logic      clr
    );
        fifo_err_t nxt;
        nxt.overflow  = ovf_evt | (cur.overflow & ~clr);
        nxt.underflow = udf_evt | (cur.underflow & ~clr);
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_ctrl_16x8.sv
// Pointer-based controller that drives a dual-port synchronous RAM as a FIFO.
// Tracks occupancy, raises sticky overflow/underflow and flags registered read data.
module fifo_ctrl_16x8
    import fifo_ctrl_16x8_pkg::*;
#(
    parameter int unsigned AW = FifoAwDefault
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr_err,
    output logic          ram_wr_enb,
    output logic [AW-1:0] ram_wr_addr,
    output logic          ram_rd_enb,
    output logic [AW-1:0] ram_rd_addr,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_rd_valid;
    fifo_err_t   r_err;

    logic        w_full;
    logic        w_empty;
    logic        w_push_ok;
    logic        w_pop_ok;
    fifo_err_t   w_err_next;

    always_comb begin
        w_empty    = (r_wr_ptr == r_rd_ptr);
        w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_push_ok  = push & ~w_full;
        w_pop_ok   = pop & ~w_empty;
        w_err_next = fifo_err_next(r_err, push & w_full, pop & w_empty, clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            // RAM registers its output on the pop edge, so valid follows one cycle later.
            r_rd_valid <= w_pop_ok;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        ram_wr_enb  = w_push_ok;
        ram_wr_addr = r_wr_ptr[AW-1:0];
        ram_rd_enb  = w_pop_ok;
        ram_rd_addr = r_rd_ptr[AW-1:0];
        rd_valid    = r_rd_valid;
        full        = w_full;
        empty       = w_empty;
        count       = r_wr_ptr - r_rd_ptr;
        overflow    = r_err.overflow;
        underflow   = r_err.underflow;
    end

endmodule

// File: tb/tb_fifo_ctrl_16x8.sv
// Randomized and directed bench for fifo_ctrl_16x8 with a behavioural RAM and queue model.
module tb_fifo_ctrl_16x8;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic          pop;
    logic          clr_err;
    logic          ram_wr_enb;
    logic [AW-1:0] ram_wr_addr;
    logic          ram_rd_enb;
    logic [AW-1:0] ram_rd_addr;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    logic [7:0]    wdata;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    ram_dout;

    int            n_vec = 0;
    int            n_err = 0;

    // Reference model: a queue of stored words plus counts of accepted operations.
    logic [7:0]    mq[$];
    int unsigned   m_wr_n;
    int unsigned   m_rd_n;
    bit            m_ovf;
    bit            m_udf;
    bit            m_valid;
    logic [7:0]    m_data;

    always #5 clk = ~clk;

    fifo_ctrl_16x8 #(.AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .clr_err     (clr_err),
        .ram_wr_enb  (ram_wr_enb),
        .ram_wr_addr (ram_wr_addr),
        .ram_rd_enb  (ram_rd_enb),
        .ram_rd_addr (ram_rd_addr),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Behavioural 16x8 synchronous RAM beside the controller.
    always @(posedge clk) begin
        if (!rst && ram_wr_enb) mem[ram_wr_addr] <= wdata;
        if (!rst && ram_rd_enb) ram_dout <= mem[ram_rd_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic p, input logic po, input logic c, input logic r,
                        input logic [7:0] d);
        bit m_full;
        bit m_empty;
        bit push_ok;
        bit pop_ok;
        @(negedge clk);
        push = p; pop = po; clr_err = c; rst = r; wdata = d;
        #1;
        m_full  = (mq.size() == DEPTH);
        m_empty = (mq.size() == 0);
        push_ok = p && !m_full;
        pop_ok  = po && !m_empty;
        check_eq("wr_enb", 32'(ram_wr_enb), 32'(push_ok));
        check_eq("rd_enb", 32'(ram_rd_enb), 32'(pop_ok));
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_wr_n = 0; m_rd_n = 0; m_ovf = 0; m_udf = 0; m_valid = 0;
        end else begin
            if (pop_ok) begin
                m_data = mq.pop_front();
                m_rd_n++;
            end
            if (push_ok) begin
                mq.push_back(d);
                m_wr_n++;
            end
            m_valid = pop_ok;
            m_ovf   = (p && m_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_udf   = (po && m_empty) ? 1'b1 : (c ? 1'b0 : m_udf);
        end
        #1;
        check_eq("count",     32'(count),       32'(mq.size()));
        check_eq("full",      32'(full),        32'(mq.size() == DEPTH));
        check_eq("empty",     32'(empty),       32'(mq.size() == 0));
        check_eq("wr_addr",   32'(ram_wr_addr), m_wr_n % DEPTH);
        check_eq("rd_addr",   32'(ram_rd_addr), m_rd_n % DEPTH);
        check_eq("overflow",  32'(overflow),    32'(m_ovf));
        check_eq("underflow", 32'(underflow),   32'(m_udf));
        check_eq("rd_valid",  32'(rd_valid),    32'(m_valid));
        if (m_valid) check_eq("rd_data", 32'(ram_dout), 32'(m_data));
    endtask

    initial begin
        int bias_p;
        int bias_q;
        push = 0; pop = 0; clr_err = 0; rst = 1; wdata = 0;
        mq.delete();
        m_wr_n = 0; m_rd_n = 0; m_ovf = 0; m_udf = 0; m_valid = 0; m_data = 0;

        // Reset and idle.
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        // Fill, overflow, drain.
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 8'(8'h11 + i));
        step(1, 0, 0, 0, 8'h99);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        // Wrap around the address space.
        step(0, 0, 0, 1, 8'h00);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'(8'h40 + 10 * k + i));
            for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 8'h00);
        end

        // Simultaneous push and pop at count 5, full and empty.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'(8'h60 + i));
        step(1, 1, 0, 0, 8'h65);
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 8'(8'h70 + i));
        step(1, 1, 0, 0, 8'hAA);
        step(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 8'h00);
        step(1, 1, 0, 0, 8'hBB);
        step(0, 0, 0, 0, 8'h00);

        // Error clearing, including clear racing a new underflow.
        step(0, 0, 0, 1, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        step(0, 1, 1, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);

        // Reset mid-stream at count 7 with a pop in the reset cycle.
        step(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 8'(8'h80 + i));
        step(1, 1, 0, 1, 8'hCC);
        step(0, 0, 0, 0, 8'h00);

        // Randomized phases with varying push/pop bias.
        for (int ph = 0; ph < 12; ph++) begin
            bias_p = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
            bias_q = 100 - bias_p;
            for (int i = 0; i < 120; i++) begin
                step($urandom_range(0, 99) < bias_p,
                     $urandom_range(0, 99) < bias_q,
                     $urandom_range(0, 99) < 5,
                     $urandom_range(0, 499) == 0,
                     8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
